sync_fifo: RTL and testbench

//   Parametrised single-clock FIFO with inferred dual-port RAM: write/read pointers, occupancy,

---
 rtl/sync_fifo.sv | 152 +++++++++++++++
 tb/tb_sync_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO over an inferred dual-port RAM with occupancy flags and drop pulses.
// With p_fwft=1 a prefetch register keeps the head word on rdata (first-word-fall-through).
module sync_fifo #(
  parameter int p_nbit_d    = 8,
  parameter int p_nbit_a    = 4,
  parameter int p_fwft      = 0,
  parameter int p_afull_th  = 12,
  parameter int p_aempty_th = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [p_nbit_d-1:0] wdata,
  input  logic                rd,
  output logic [p_nbit_d-1:0] rdata,
  output logic                rvalid,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [p_nbit_a:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int                lp_depth    = 1 << p_nbit_a;
  localparam logic [p_nbit_a:0] lp_depth_c  = (p_nbit_a + 1)'(lp_depth);
  localparam logic [p_nbit_a:0] lp_afull_c  = (p_nbit_a + 1)'(p_afull_th);
  localparam logic [p_nbit_a:0] lp_aempty_c = (p_nbit_a + 1)'(p_aempty_th);
  localparam logic [p_nbit_a:0] lp_cnt_zero = '0;
  localparam logic [p_nbit_a:0] lp_cnt_one  = (p_nbit_a + 1)'(1);
  localparam logic [p_nbit_a-1:0] lp_ptr_one = p_nbit_a'(1);

  logic [p_nbit_d-1:0] mem_q [lp_depth];

  logic [p_nbit_a-1:0] wptr_q, wptr_d;
  logic [p_nbit_a-1:0] rptr_q, rptr_d;
  logic [p_nbit_a:0]   count_q, count_d;
  logic [p_nbit_d-1:0] rdata_q;
  logic                valid_q, valid_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                afull_q, afull_d;
  logic                aempty_q, aempty_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic                wr_acc_s;
  logic                rd_acc_s;
  logic                fetch_s;
  logic [p_nbit_a:0]   ram_words_s;

  // Accept/fetch decisions and next-state for pointers, occupancy and flags.
  always_comb begin
    wr_acc_s    = wr & ~full_q;
    rd_acc_s    = rd & ~empty_q;
    ram_words_s = lp_cnt_zero;
    fetch_s     = 1'b0;
    valid_d     = 1'b0;

    // In FWFT, valid_q marks a loaded head word; RAM holds the rest of count.
    if (p_fwft != 0) begin
      ram_words_s = count_q - {{p_nbit_a{1'b0}}, valid_q};
      fetch_s     = (~valid_q | rd_acc_s) & (ram_words_s != lp_cnt_zero);
      valid_d     = fetch_s | (valid_q & ~rd_acc_s);
    end else begin
      fetch_s     = rd_acc_s;
      valid_d     = rd_acc_s;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + lp_cnt_one;
      2'b01:   count_d = count_q - lp_cnt_one;
      default: count_d = count_q;
    endcase

    if (wr_acc_s) begin
      wptr_d = wptr_q + lp_ptr_one;
    end else begin
      wptr_d = wptr_q;
    end

    if (fetch_s) begin
      rptr_d = rptr_q + lp_ptr_one;
    end else begin
      rptr_d = rptr_q;
    end

    if (p_fwft != 0) begin
      empty_d = ~valid_d;
    end else begin
      empty_d = (count_d == lp_cnt_zero);
    end

    full_d   = (count_d == lp_depth_c);
    afull_d  = (count_d >= lp_afull_c);
    aempty_d = (count_d <= lp_aempty_c);
    ovf_d    = wr & full_q;
    unf_d    = rd & empty_q;
  end

  // RAM write port; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s & ~rst) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Control state and the registered read port (head register in FWFT).
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      if (fetch_s) begin
        rdata_q <= mem_q[rptr_q];
      end else begin
        rdata_q <= rdata_q;
      end
    end
  end

  assign rdata        = rdata_q;
  assign rvalid       = valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: one standard-mode and one FWFT-mode FIFO driven by a linear step sequence.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] q_model [$];
  logic [7:0] exp_v;

  logic       s_wr, s_rd, s_rvalid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
  logic [7:0] s_wdata, s_rdata;
  logic [4:0] s_count;

  logic       f_wr, f_rd, f_rvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [7:0] f_wdata, f_rdata;
  logic [4:0] f_count;

  always #5 clk = ~clk;

  sync_fifo #(.p_nbit_d(8), .p_nbit_a(4), .p_fwft(0), .p_afull_th(12), .p_aempty_th(2)) u_std (
    .clk(clk), .rst(rst), .wr(s_wr), .wdata(s_wdata), .rd(s_rd), .rdata(s_rdata),
    .rvalid(s_rvalid), .full(s_full), .empty(s_empty), .almost_full(s_afull),
    .almost_empty(s_aempty), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo #(.p_nbit_d(8), .p_nbit_a(4), .p_fwft(1), .p_afull_th(12), .p_aempty_th(2)) u_fw (
    .clk(clk), .rst(rst), .wr(f_wr), .wdata(f_wdata), .rd(f_rd), .rdata(f_rdata),
    .rvalid(f_rvalid), .full(f_full), .empty(f_empty), .almost_full(f_afull),
    .almost_empty(f_aempty), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_wr = 1'b0; s_rd = 1'b0; s_wdata = 8'h00;
    f_wr = 1'b0; f_rd = 1'b0; f_wdata = 8'h00;
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_count", 32'(s_count), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_full", 32'(s_full), 32'd0);
    chk("rst_aempty", 32'(s_aempty), 32'd1);
    chk("rst_afull", 32'(s_afull), 32'd0);
    chk("rst_rdata", 32'(s_rdata), 32'd0);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_fw_empty", 32'(f_empty), 32'd1);

    // 1: fill 0x01..0x10, then overflow
    for (int i = 1; i <= 16; i++) begin
      s_wr = 1'b1; s_wdata = 8'(i);
      tick();
      chk("fill_count", 32'(s_count), 32'(i));
      chk("fill_afull", 32'(s_afull), 32'(i >= 12));
      chk("fill_aempty", 32'(s_aempty), 32'(i <= 2));
      chk("fill_full", 32'(s_full), 32'(i == 16));
      chk("fill_empty", 32'(s_empty), 32'd0);
    end
    s_wdata = 8'hFF;
    tick();
    chk("ovf_pulse", 32'(s_ovf), 32'd1);
    chk("ovf_count", 32'(s_count), 32'd16);
    s_wr = 1'b0;
    tick();
    chk("ovf_clear", 32'(s_ovf), 32'd0);

    // 2: drain in order with one-cycle latency, then underflow
    for (int i = 1; i <= 16; i++) begin
      s_rd = 1'b1;
      tick();
      chk("drain_rdata", 32'(s_rdata), 32'(i));
      chk("drain_rvalid", 32'(s_rvalid), 32'd1);
      chk("drain_count", 32'(s_count), 32'(16 - i));
      chk("drain_empty", 32'(s_empty), 32'(i == 16));
      chk("drain_aempty", 32'(s_aempty), 32'((16 - i) <= 2));
    end
    tick();
    chk("unf_pulse", 32'(s_unf), 32'd1);
    chk("unf_rvalid", 32'(s_rvalid), 32'd0);
    chk("unf_hold", 32'(s_rdata), 32'h10);
    s_rd = 1'b0;
    tick();
    chk("unf_clear", 32'(s_unf), 32'd0);

    // 3: pointer wrap with write 10, read 10, write 16, read 16
    for (int i = 0; i < 10; i++) begin
      s_wr = 1'b1; s_wdata = 8'(8'h20 + i); q_model.push_back(s_wdata);
      tick();
    end
    s_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_rd = 1'b1;
      tick();
      exp_v = q_model.pop_front();
      chk("wrap_a_rdata", 32'(s_rdata), 32'(exp_v));
    end
    s_rd = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_wr = 1'b1; s_wdata = 8'(8'hA0 + i); q_model.push_back(s_wdata);
      tick();
    end
    s_wr = 1'b0;
    chk("wrap_full", 32'(s_full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      s_rd = 1'b1;
      tick();
      exp_v = q_model.pop_front();
      chk("wrap_b_rdata", 32'(s_rdata), 32'(exp_v));
    end
    s_rd = 1'b0;
    chk("wrap_empty", 32'(s_empty), 32'd1);

    // 4: simultaneous write+read at count 5
    for (int i = 0; i < 5; i++) begin
      s_wr = 1'b1; s_wdata = 8'(8'h40 + i); q_model.push_back(s_wdata);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      s_wr = 1'b1; s_rd = 1'b1; s_wdata = 8'(8'h50 + i);
      exp_v = q_model.pop_front();
      q_model.push_back(s_wdata);
      tick();
      chk("rw_count", 32'(s_count), 32'd5);
      chk("rw_rdata", 32'(s_rdata), 32'(exp_v));
    end
    s_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_rd = 1'b1;
      exp_v = q_model.pop_front();
      tick();
      chk("rw_tail_rdata", 32'(s_rdata), 32'(exp_v));
    end
    s_rd = 1'b0;
    tick();
    chk("rw_empty", 32'(s_empty), 32'd1);

    // 5: FWFT latency and full-rate pops
    f_wr = 1'b1; f_wdata = 8'hA5; q_model.push_back(f_wdata);
    tick();
    f_wr = 1'b0;
    chk("fw_k1_empty", 32'(f_empty), 32'd1);
    chk("fw_k1_count", 32'(f_count), 32'd1);
    tick();
    chk("fw_k2_empty", 32'(f_empty), 32'd0);
    chk("fw_k2_rdata", 32'(f_rdata), 32'hA5);
    chk("fw_k2_rvalid", 32'(f_rvalid), 32'd1);
    for (int i = 0; i < 15; i++) begin
      f_wr = 1'b1; f_wdata = 8'(8'h61 + i); q_model.push_back(f_wdata);
      tick();
    end
    f_wr = 1'b0;
    chk("fw_full", 32'(f_full), 32'd1);
    chk("fw_count16", 32'(f_count), 32'd16);
    f_rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_v = q_model.pop_front();
      chk("fw_pop_rdata", 32'(f_rdata), 32'(exp_v));
      chk("fw_pop_empty", 32'(f_empty), 32'd0);
      tick();
    end
    f_rd = 1'b0;
    chk("fw_drained_empty", 32'(f_empty), 32'd1);
    chk("fw_drained_count", 32'(f_count), 32'd0);
    chk("fw_drained_unf", 32'(f_unf), 32'd0);

    // 6: reset mid-stream at count 9
    for (int i = 0; i < 10; i++) begin
      s_wr = 1'b1; s_wdata = 8'(8'h70 + i);
      tick();
    end
    s_wr = 1'b0; s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    chk("mid_count", 32'(s_count), 32'd9);
    chk("mid_rdata", 32'(s_rdata), 32'h70);
    rst = 1'b1; s_wr = 1'b1; s_wdata = 8'hEE;
    tick();
    rst = 1'b0; s_wr = 1'b0;
    chk("mrst_count", 32'(s_count), 32'd0);
    chk("mrst_empty", 32'(s_empty), 32'd1);
    chk("mrst_rdata", 32'(s_rdata), 32'd0);
    chk("mrst_rvalid", 32'(s_rvalid), 32'd0);
    chk("mrst_aempty", 32'(s_aempty), 32'd1);
    s_wr = 1'b1; s_wdata = 8'h33;
    tick();
    s_wr = 1'b0; s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    chk("post_rst_rdata", 32'(s_rdata), 32'h33);
    chk("post_rst_rvalid", 32'(s_rvalid), 32'd1);
    chk("post_rst_empty", 32'(s_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
